// File: rtl/sarray_ld_seq.sv
// Systolic-tile load sequencer: strided bounded-outstanding reads, zero-latency R routing to A buffer or stream.
// Backpressure from st_ready_i stalls R for TMMA/PRELOADC; define SARRAY_LD_SEQ_PERF_EN for busy/stall counters.
module sarray_ld_seq #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int BEATS     = 64,
  parameter int STRIDE    = 256,
  parameter int MAX_OUTST = 8,
  parameter int PREC_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tinst_valid_i,
  output logic                     tinst_ready_o,
  input  logic [1:0]               tinst_type_i,
  input  logic [ADDR_W-1:0]        tinst_addr_i,
  input  logic [PREC_W-1:0]        tinst_precision_i,
  input  logic                     tinst_acc_i,
  output logic                     ar_valid_o,
  input  logic                     ar_ready_i,
  output logic [ADDR_W-1:0]        ar_addr_o,
  input  logic                     r_valid_i,
  output logic                     r_ready_o,
  input  logic [DATA_W-1:0]        r_data_i,
  output logic                     abuf_wr_valid_o,
  output logic                     abuf_wr_id_o,
  output logic [$clog2(BEATS)-1:0] abuf_wr_addr_o,
  output logic [DATA_W-1:0]        abuf_wr_data_o,
  output logic                     abuf_rd_id_o,
  output logic                     st_valid_o,
  input  logic                     st_ready_i,
  output logic [DATA_W-1:0]        st_data_o,
  output logic [$clog2(BEATS)-1:0] st_cnt_o,
  output logic                     st_type_o,
  output logic [PREC_W-1:0]        st_precision_o,
  output logic                     st_acc_o,
  output logic                     done_o,
  output logic [1:0]               done_type_o
`ifdef SARRAY_LD_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_busy_o,
  output logic [31:0]              perf_stall_o
`endif
);

  localparam int IDX_W = $clog2(BEATS);
  localparam int OST_W = $clog2(MAX_OUTST + 1);
  localparam logic [IDX_W:0]   BEATS_C = (IDX_W + 1)'(BEATS);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(BEATS - 1);
  localparam logic [OST_W-1:0] MAXO_C  = OST_W'(MAX_OUTST);

  localparam logic [1:0] T_TMMA = 2'd0;
  localparam logic [1:0] T_PREA = 2'd1;
  localparam logic [1:0] T_PREC = 2'd2;
  localparam logic [1:0] T_RSVD = 2'd3;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [PREC_W-1:0]   prec_q, prec_d;
  logic                acc_q, acc_d;
  logic [IDX_W:0]      ar_idx_q, ar_idx_d;
  logic [IDX_W-1:0]    r_idx_q, r_idx_d;
  logic [OST_W-1:0]    outst_q, outst_d;
  logic                rd_bank_q, rd_bank_d;
  logic                wr_bank_q, wr_bank_d;
  logic                done_q, done_d;
  logic [1:0]          done_type_q, done_type_d;

  logic run;
  logic is_prea;
  logic accept;
  logic ar_hs;
  logic r_hs;
  logic last_beat;

  assign run       = (state_q == S_RUN);
  assign is_prea   = (type_q == T_PREA);
  assign accept    = tinst_valid_i & tinst_ready_o & (tinst_type_i != T_RSVD);
  assign ar_hs     = ar_valid_o & ar_ready_i;
  assign r_hs      = r_valid_i & r_ready_o;
  assign last_beat = r_hs & (r_idx_q == LAST_C);

  assign tinst_ready_o = (state_q == S_IDLE);
  assign ar_valid_o    = run & (ar_idx_q < BEATS_C) & (outst_q < MAXO_C);
  assign ar_addr_o     = ar_addr_q;
  // Beats arriving while idle are a protocol error and are never accepted.
  assign r_ready_o     = run & (is_prea | st_ready_i);

  assign abuf_wr_valid_o = r_valid_i & run & is_prea;
  assign abuf_wr_id_o    = wr_bank_q;
  assign abuf_wr_addr_o  = r_idx_q;
  assign abuf_wr_data_o  = r_data_i;
  assign abuf_rd_id_o    = rd_bank_q;

  assign st_valid_o     = r_valid_i & run & ~is_prea;
  assign st_data_o      = r_data_i;
  assign st_cnt_o       = r_idx_q;
  assign st_type_o      = (type_q == T_PREC);
  assign st_precision_o = prec_q;
  assign st_acc_o       = acc_q;

  assign done_o      = done_q;
  assign done_type_o = done_type_q;

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    ar_addr_d   = ar_addr_q;
    prec_d      = prec_q;
    acc_d       = acc_q;
    ar_idx_d    = ar_idx_q;
    r_idx_d     = r_idx_q;
    outst_d     = outst_q;
    rd_bank_d   = rd_bank_q;
    wr_bank_d   = wr_bank_q;
    done_d      = 1'b0;
    done_type_d = done_type_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_RUN;
          type_d    = tinst_type_i;
          ar_addr_d = tinst_addr_i;
          prec_d    = tinst_precision_i;
          acc_d     = tinst_acc_i;
          ar_idx_d  = '0;
          r_idx_d   = '0;
          outst_d   = '0;
        end
      end
      S_RUN: begin
        if (ar_hs) begin
          ar_idx_d  = ar_idx_q + 1'b1;
          ar_addr_d = ar_addr_q + ADDR_W'(STRIDE);
        end
        // Simultaneous request and return leave the count unchanged; an unsolicited return cannot underflow it.
        if (ar_hs && !r_hs) begin
          outst_d = outst_q + 1'b1;
        end else if (!ar_hs && r_hs && (outst_q != '0)) begin
          outst_d = outst_q - 1'b1;
        end
        if (r_hs) begin
          r_idx_d = r_idx_q + 1'b1;
        end
        if (last_beat) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          done_type_d = type_q;
          if (is_prea) begin
            rd_bank_d = wr_bank_q;
            wr_bank_d = ~wr_bank_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      type_q      <= T_TMMA;
      ar_addr_q   <= '0;
      prec_q      <= '0;
      acc_q       <= 1'b0;
      ar_idx_q    <= '0;
      r_idx_q     <= '0;
      outst_q     <= '0;
      rd_bank_q   <= 1'b0;
      wr_bank_q   <= 1'b1;
      done_q      <= 1'b0;
      done_type_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      ar_addr_q   <= ar_addr_d;
      prec_q      <= prec_d;
      acc_q       <= acc_d;
      ar_idx_q    <= ar_idx_d;
      r_idx_q     <= r_idx_d;
      outst_q     <= outst_d;
      rd_bank_q   <= rd_bank_d;
      wr_bank_q   <= wr_bank_d;
      done_q      <= done_d;
      done_type_q <= done_type_d;
    end
  end

`ifdef SARRAY_LD_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;
  logic        stall;

  assign stall        = run & ((r_valid_i & ~r_ready_o) | (ar_valid_o & ~ar_ready_i));
  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (run && (perf_busy_q != 32'hFFFF_FFFF)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end
`endif

endmodule
